// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: synchronous word memory with byte/half/word loads and stores, valid/ready
// request/response handshake, alignment/range error flagging and a post-reset clear sweep.
module data_memory_ctrl #(
   parameter int AW           = 8,
   parameter bit ZERO_PROTECT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_done
);
   localparam int DEPTH = 1 << AW;
   typedef enum logic [1:0] {INIT, IDLE, RESP} state_e;
   state_e        state_q, state_d;
   logic [AW-1:0] clr_cnt_q;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   word_q;
   logic [1:0]    lane_q, size_q;
   logic          uns_q, ld_q, err_q;
   logic          acc, err, hit0;
   logic [AW-1:0] widx;
   logic [3:0]    be;
   logic [31:0]   wd, sh;
   assign widx = req_addr[AW+1:2];
   assign hit0 = ZERO_PROTECT && widx == '0;
   assign acc  = req_valid & req_ready;
   assign err  = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                 (req_size == 2'b10 & |req_addr[1:0]) | |(req_addr >> (AW + 2));
   assign be   = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                 req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wd   = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                 req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         INIT: if (&clr_cnt_q) state_d = IDLE;
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            req_ready = rsp_ready;
            if (rsp_ready) state_d = req_valid ? RESP : IDLE;
         end
         default: state_d = INIT;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= INIT;
         clr_cnt_q <= '0;
         lane_q    <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         ld_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) clr_cnt_q <= clr_cnt_q + 1'b1;
         if (acc) begin
            lane_q <= req_addr[1:0];
            size_q <= req_size;
            uns_q  <= req_unsigned;
            err_q  <= err;
            ld_q   <= !req_we && !err && !hit0;
         end
      end
   end
   // The array has no reset; the INIT sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (state_q == INIT) mem[clr_cnt_q] <= '0;
      for (int i = 0; i < 4; i++)
         if (acc && req_we && !err && !hit0 && be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
      if (acc) word_q <= mem[widx];
   end
   assign sh        = word_q >> {lane_q, 3'b000};
   assign rsp_rdata = !ld_q ? '0 :
                      size_q == 2'b00 ? {{24{!uns_q & sh[7]}}, sh[7:0]} :
                      size_q == 2'b01 ? {{16{!uns_q & sh[15]}}, sh[15:0]} : word_q;
   assign rsp_err   = err_q;
   assign init_done = state_q != INIT;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and randomized checks against a byte-addressed reference model.
module tb_data_memory_ctrl;
   localparam int NB = 1024;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, init_done;
   logic [31:0] rsp_rdata;
   typedef struct {logic [31:0] d; logic e;} rsp_t;
   rsp_t        exp_q[$];
   logic [7:0]  mb [NB];
   int          checks = 0, failures = 0;
   bit          acc_f, rsp_f;
   logic [31:0] last_rd, rd;
   logic        last_err, er;
   data_memory_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .init_done(init_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // Bytes 0..3 (word 0) are write-protected and read as zero.
   function automatic void model(input bit we, input logic [1:0] sz, input bit un, input logic [31:0] a,
                                 input logic [31:0] wd);
      int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      rsp_t r = '{32'd0, 1'b0};
      if (sz == 2'd3 || a % n != 0 || a >= NB) r.e = 1'b1;
      else if (we) begin
         if (a >= 4) for (int i = 0; i < n; i++) mb[a + i] = wd[8*i +: 8];
      end else if (a >= 4) begin
         for (int i = 0; i < n; i++) r.d = r.d | (32'(mb[a + i]) << (8 * i));
         if (!un && n < 4 && r.d[8*n-1]) r.d = r.d | (32'hFFFF_FFFF << (8 * n));
      end
      exp_q.push_back(r);
   endfunction
   task automatic cyc(input bit v, input bit we, input logic [1:0] sz, input bit un, input logic [31:0] a,
                      input logic [31:0] wd, input bit rr);
      rsp_t e;
      req_valid = v; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
      rsp_ready = rr;
      #1;
      if (rsp_valid && rsp_ready) begin
         rsp_f = 1'b1; last_rd = rsp_rdata; last_err = rsp_err;
         if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.d);
            chk("rsp_err", 32'(rsp_err), 32'(e.e));
         end
      end
      if (req_valid && req_ready) begin
         acc_f = 1'b1;
         model(we, sz, un, a, wd);
      end
      @(negedge clk);
   endtask
   task automatic xfer(input bit we, input logic [1:0] sz, input bit un, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] d, output logic e);
      acc_f = 1'b0;
      for (int n = 0; n < 50 && !acc_f; n++) cyc(1'b1, we, sz, un, a, wd, 1'b1);
      if (!acc_f) chk("accept_timeout", 0, 1);
      rsp_f = 1'b0;
      for (int n = 0; n < 50 && !rsp_f; n++) cyc(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      if (!rsp_f) chk("rsp_timeout", 0, 1);
      d = last_rd; e = last_err;
   endtask
   initial begin
      for (int i = 0; i < NB; i++) mb[i] = 8'h00;
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h3FC; req_wdata = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", 32'(rsp_err), 0);
      chk("rst_init_done", 32'(init_done), 0);
      rst = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         if (k == 1 || k == 255) begin
            chk("init_ready_lo", 32'(req_ready), 0);
            chk("init_done_lo", 32'(init_done), 0);
         end
      end
      chk("init_ready_hi", 32'(req_ready), 1);
      chk("init_done_hi", 32'(init_done), 1);
      xfer(0, 2'd2, 0, 32'h3FC, 0, rd, er); chk("lw_3fc", rd, 32'h0);
      xfer(1, 2'd2, 0, 32'h10, 32'h80817F01, rd, er);
      xfer(0, 2'd0, 0, 32'h10, 0, rd, er); chk("lb_10", rd, 32'h00000001);
      xfer(0, 2'd0, 0, 32'h11, 0, rd, er); chk("lb_11", rd, 32'h0000007F);
      xfer(0, 2'd0, 0, 32'h12, 0, rd, er); chk("lb_12", rd, 32'hFFFFFF81);
      xfer(0, 2'd1, 1, 32'h12, 0, rd, er); chk("lhu_12", rd, 32'h00008081);
      xfer(0, 2'd1, 0, 32'h12, 0, rd, er); chk("lh_12", rd, 32'hFFFF8081);
      xfer(0, 2'd2, 0, 32'h10, 0, rd, er); chk("lw_10", rd, 32'h80817F01);
      xfer(1, 2'd2, 0, 32'h20, 32'h0, rd, er);
      xfer(1, 2'd0, 0, 32'h21, 32'h123456AB, rd, er);
      xfer(1, 2'd1, 0, 32'h22, 32'h9876CDEF, rd, er);
      xfer(0, 2'd2, 0, 32'h20, 0, rd, er); chk("lane_merge", rd, 32'hCDEFAB00);
      xfer(0, 2'd2, 0, 32'h22, 0, rd, er);
      chk("err_lw_mis", 32'(er), 1); chk("err_lw_mis_d", rd, 0);
      xfer(0, 2'd1, 0, 32'h13, 0, rd, er); chk("err_lh_mis", 32'(er), 1);
      xfer(0, 2'd3, 0, 32'h20, 0, rd, er); chk("err_size", 32'(er), 1);
      xfer(1, 2'd2, 0, 32'h400, 32'hDEADBEEF, rd, er); chk("err_range", 32'(er), 1);
      xfer(0, 2'd2, 0, 32'h20, 0, rd, er); chk("err_no_write", rd, 32'hCDEFAB00);
      acc_f = 1'b0;
      for (int n = 0; n < 50 && !acc_f; n++) cyc(1, 0, 2'd2, 0, 32'h10, 0, 1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h55AA55AA; rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_valid", 32'(rsp_valid), 1);
         chk("stall_ready", 32'(req_ready), 0);
         chk("stall_rdata", rsp_rdata, 32'h80817F01);
         @(negedge clk);
      end
      rsp_f = 1'b0; cyc(1, 1, 2'd2, 0, 32'h30, 32'h55AA55AA, 1); chk("b2b_rsp1", 32'(rsp_f), 1);
      rsp_f = 1'b0; cyc(1, 0, 2'd2, 0, 32'h30, 0, 1); chk("b2b_rsp2", 32'(rsp_f), 1);
      rsp_f = 1'b0; cyc(0, 0, 2'd0, 0, 0, 0, 1); chk("b2b_rsp3", 32'(rsp_f), 1);
      chk("b2b_data", last_rd, 32'h55AA55AA);
      for (int c = 0; c < 600; c++) begin
         logic [1:0]  sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
         logic [31:0] a  = $urandom_range(0, 19) == 0 ? $urandom : 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 8) a = sz == 2'd1 ? a & ~32'd1 : sz == 2'd2 ? a & ~32'd3 : a;
         cyc($urandom_range(0, 3) != 0, 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3) != 0);
      end
      for (int c = 0; c < 5; c++) cyc(0, 0, 2'd0, 0, 0, 0, 1);
      chk("drain_empty", exp_q.size(), 0);
      xfer(1, 2'd2, 0, 32'h0, 32'hFFFFFFFF, rd, er); chk("zp_store_err", 32'(er), 0);
      xfer(0, 2'd2, 0, 32'h0, 0, rd, er); chk("zp_load", rd, 0);
      xfer(1, 2'd2, 0, 32'h30, 32'h13572468, rd, er);
      acc_f = 1'b0;
      for (int n = 0; n < 50 && !acc_f; n++) cyc(1, 0, 2'd2, 0, 32'h30, 0, 1);
      req_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      chk("mid_rsp_valid", 32'(rsp_valid), 1);
      chk("mid_rdata", rsp_rdata, 32'h13572468);
      rst = 1'b0;
      #1;
      chk("arst_rsp_valid", 32'(rsp_valid), 0);
      chk("arst_rdata", rsp_rdata, 0);
      chk("arst_ready", 32'(req_ready), 0);
      chk("arst_init_done", 32'(init_done), 0);
      exp_q.delete();
      for (int i = 0; i < NB; i++) mb[i] = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 300 && !init_done; n++) @(negedge clk);
      chk("reinit_done", 32'(init_done), 1);
      xfer(0, 2'd2, 0, 32'h30, 0, rd, er); chk("reinit_lw_30", rd, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
